mmio_device_regs: RTL

MMIO_DEVICE_REGS -- requirements
Module: mmio_device_regs

---
 rtl/mmio_device_regs_pkg.sv | 31 +++
 rtl/mmio_device_regs_kb_rx_fifo.sv | 60 ++++++
 rtl/mmio_device_regs.sv | 100 ++++++++++
 3 files changed

// File: rtl/mmio_device_regs_pkg.sv
// Shared MMIO map, read-mux encodings, status bit positions and display FSM state type
// for the keyboard/display register block.
package mmio_device_regs_pkg;

   localparam logic [15:0] ADDR_KBDR = 16'h03F0;
   localparam logic [15:0] ADDR_KBSR = 16'h03F1;
   localparam logic [15:0] ADDR_DSR  = 16'h03F2;
   localparam logic [15:0] ADDR_DDR  = 16'h03F3;

   localparam logic [1:0] SEL_KBDR = 2'b00;
   localparam logic [1:0] SEL_KBSR = 2'b01;
   localparam logic [1:0] SEL_DSR  = 2'b10;
   localparam logic [1:0] SEL_MEM  = 2'b11;

   localparam int unsigned BIT_RDY = 15;
   localparam int unsigned BIT_IE  = 14;

   typedef enum logic {
      DISP_IDLE = 1'b0,
      DISP_SEND = 1'b1
   } disp_state_t;

   function automatic logic [15:0] status_word(input logic rdy, input logic ie);
      logic [15:0] w;
      w          = '0;
      w[BIT_RDY] = rdy;
      w[BIT_IE]  = ie;
      return w;
   endfunction

endpackage

// File: rtl/mmio_device_regs_kb_rx_fifo.sv
// Keyboard receive FIFO: push guarded by full, pop guarded by empty, head always visible.
module kb_rx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       empty_o,
   output logic       full_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/mmio_device_regs.sv
// Memory-mapped keyboard/display registers: KBSR/KBDR over a receive FIFO,
// DSR/DDR over a two-state display transmit FSM, plus the MDR read mux.
module mmio_device_regs
   import mmio_device_regs_pkg::*;
#(
   parameter int unsigned KB_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mdr_in,
   input  logic [15:0] mem_out,
   input  logic [1:0]  inmux_sel,
   input  logic        ld_kbsr,
   input  logic        ld_ddr,
   input  logic        ld_dsr,
   input  logic        kbdr_rd,
   output logic [15:0] mio_data,
   input  logic [7:0]  kb_data,
   input  logic        kb_valid,
   output logic        kb_ready,
   output logic [7:0]  disp_data,
   output logic        disp_valid,
   input  logic        disp_ready,
   output logic        kb_irq,
   output logic        disp_irq
);

   disp_state_t state_q, state_d;
   logic [7:0]  ddr_q, ddr_d;
   logic        kb_ie_q, disp_ie_q;
   logic [7:0]  fifo_head;
   logic        fifo_empty, fifo_full;
   logic [15:0] kbsr, dsr;
   logic        unused_mdr_bits;

   assign unused_mdr_bits = ^{mdr_in[15], mdr_in[13:8]};

   kb_rx_fifo #(.DEPTH(KB_DEPTH)) u_kb_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (kb_valid & kb_ready),
      .data_i  (kb_data),
      .pop_i   (kbdr_rd),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign kb_ready = ~fifo_full;
   assign kbsr     = status_word(~fifo_empty, kb_ie_q);
   assign dsr      = status_word(state_q == DISP_IDLE, disp_ie_q);
   assign kb_irq   = kbsr[BIT_RDY] & kbsr[BIT_IE];
   assign disp_irq = dsr[BIT_RDY] & dsr[BIT_IE];
   assign disp_data = ddr_q;

   always_comb begin
      mio_data = '0;
      case (inmux_sel)
         SEL_KBDR: mio_data = fifo_empty ? '0 : {8'h00, fifo_head};
         SEL_KBSR: mio_data = kbsr;
         SEL_DSR:  mio_data = dsr;
         default:  mio_data = mem_out;
      endcase
   end

   // A DDR store arriving while a character is in flight is dropped, not queued
   always_comb begin
      state_d    = state_q;
      ddr_d      = ddr_q;
      disp_valid = 1'b0;
      case (state_q)
         DISP_IDLE: begin
            if (ld_ddr) begin
               ddr_d   = mdr_in[7:0];
               state_d = DISP_SEND;
            end
         end
         DISP_SEND: begin
            disp_valid = 1'b1;
            if (disp_ready) state_d = DISP_IDLE;
         end
         default: state_d = DISP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= DISP_IDLE;
         ddr_q     <= '0;
         kb_ie_q   <= 1'b0;
         disp_ie_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ddr_q   <= ddr_d;
         if (ld_kbsr) kb_ie_q   <= mdr_in[BIT_IE];
         if (ld_dsr)  disp_ie_q <= mdr_in[BIT_IE];
      end
   end

endmodule
